// File: rtl/filter_sched_pkg.sv
// Shared definitions for the filter line scheduler: state encoding, default line
// length and line-buffer select codes.
package filter_sched_pkg;

    localparam int LINE_WORDS_DEF = 64;
    localparam int ROWS_W         = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_FILL   = 3'd2,
        ST_FILTER = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] SEL_LINE1 = 2'd1;
    localparam logic [1:0] SEL_LINE2 = 2'd2;
    localparam logic [1:0] SEL_LINE3 = 2'd3;

endpackage

// File: rtl/filter_line_sched.sv
// Fetches three image lines into the filter line buffers, runs the filter for one
// output row, repeats per row. Optional SCHED_PERF_CNT_EN adds a job cycle counter.
module filter_line_sched
    import filter_sched_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [11:0]       i_num_rows,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_data_valid,
    input  logic [63:0]       i_rd_data,
    output logic              o_line1_data_valid,
    output logic              o_line2_data_valid,
    output logic              o_line3_data_valid,
    output logic [63:0]       o_line_data,
    output logic              o_filter,
    input  logic              i_out_beat,
    output logic              o_busy,
    output logic              o_done
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       o_job_cycles
`endif
);

    localparam int CNT_W = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [ROWS_W-1:0]   row_reg, row_next;
    logic [1:0]          sel_reg, sel_next;
    logic                drain_reg, drain_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [ADDR_W-1:0]   stride_reg, stride_next;
    logic [ROWS_W-1:0]   rows_reg, rows_next;

    logic [ADDR_W-1:0]   line_idx;
    logic [ADDR_W-1:0]   line_addr;
    logic [ROWS_W-1:0]   row_inc;
    logic                fill_beat;

    // Input line for the current fetch is row + sel - 1; everything wraps at ADDR_W.
    assign line_idx  = ADDR_W'(row_reg) + ADDR_W'(sel_reg) - ADDR_W'(1);
    assign line_addr = base_reg + line_idx * stride_reg;
    assign row_inc   = row_reg + ROWS_W'(1);
    assign fill_beat = (state_reg == ST_FILL) && i_rd_data_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            beat_cnt_reg <= '0;
            row_reg      <= '0;
            sel_reg      <= '0;
            drain_reg    <= 1'b0;
            base_reg     <= '0;
            stride_reg   <= '0;
            rows_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            row_reg      <= row_next;
            sel_reg      <= sel_next;
            drain_reg    <= drain_next;
            base_reg     <= base_next;
            stride_reg   <= stride_next;
            rows_reg     <= rows_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        row_next      = row_reg;
        sel_next      = sel_reg;
        drain_next    = drain_reg;
        base_next     = base_reg;
        stride_next   = stride_reg;
        rows_next     = rows_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    base_next     = i_base_addr;
                    stride_next   = i_stride;
                    rows_next     = i_num_rows;
                    row_next      = '0;
                    sel_next      = SEL_LINE1;
                    beat_cnt_next = '0;
                    state_next    = (i_num_rows >= ROWS_W'(3)) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (i_rd_ack) begin
                    beat_cnt_next = '0;
                    state_next    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (i_rd_data_valid) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        if (sel_reg == SEL_LINE3) begin
                            state_next = ST_FILTER;
                        end else begin
                            sel_next   = sel_reg + 2'd1;
                            state_next = ST_REQ;
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_FILTER: begin
                if (i_out_beat) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        drain_next    = 1'b0;
                        state_next    = ST_DRAIN;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Two idle cycles let the filter's read side settle back to idle.
                if (!drain_reg) begin
                    drain_next = 1'b1;
                end else begin
                    drain_next = 1'b0;
                    row_next   = row_inc;
                    if (row_inc < (rows_reg - ROWS_W'(2))) begin
                        sel_next   = SEL_LINE1;
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_rd_req           = (state_reg == ST_REQ);
        o_rd_addr          = (state_reg == ST_REQ) ? line_addr : '0;
        o_line1_data_valid = fill_beat && (sel_reg == SEL_LINE1);
        o_line2_data_valid = fill_beat && (sel_reg == SEL_LINE2);
        o_line3_data_valid = fill_beat && (sel_reg == SEL_LINE3);
        o_line_data        = i_rd_data;
        o_filter           = (state_reg == ST_FILTER);
        o_busy             = (state_reg != ST_IDLE);
        o_done             = (state_reg == ST_DONE);
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] job_cycles_reg;

    // Counts every non-idle cycle of a job, so the value after o_done is the job length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            job_cycles_reg <= '0;
        end else if ((state_reg == ST_IDLE) && i_start) begin
            job_cycles_reg <= '0;
        end else if ((state_reg != ST_IDLE) && (job_cycles_reg != 32'hFFFF_FFFF)) begin
            job_cycles_reg <= job_cycles_reg + 32'd1;
        end
    end

    assign o_job_cycles = job_cycles_reg;
`endif

endmodule

// File: tb/tb_filter_line_sched.sv
// Self-checking bench for filter_line_sched: job table plus reset-in-FILL sequence,
// read scoreboard, strobe routing and filter window monitor.
module tb_filter_line_sched;
    localparam int LW = 64;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [31:0] i_stride = '0;
    logic [11:0] i_num_rows = '0;
    logic        o_rd_req;
    logic [31:0] o_rd_addr;
    logic        i_rd_ack = 1'b0;
    logic        i_rd_data_valid = 1'b0;
    logic [63:0] i_rd_data = '0;
    logic        o_line1_data_valid, o_line2_data_valid, o_line3_data_valid;
    logic [63:0] o_line_data;
    logic        o_filter;
    logic        i_out_beat = 1'b0;
    logic        o_busy;
    logic        o_done;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] o_job_cycles;
`endif

    filter_line_sched #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_stride(i_stride), .i_num_rows(i_num_rows),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_ack(i_rd_ack),
        .i_rd_data_valid(i_rd_data_valid), .i_rd_data(i_rd_data),
        .o_line1_data_valid(o_line1_data_valid), .o_line2_data_valid(o_line2_data_valid),
        .o_line3_data_valid(o_line3_data_valid), .o_line_data(o_line_data),
        .o_filter(o_filter), .i_out_beat(i_out_beat), .o_busy(o_busy), .o_done(o_done)
`ifdef SCHED_PERF_CNT_EN
        , .o_job_cycles(o_job_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          line;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    typedef struct {
        int          n_rows;
        logic [31:0] base;
        logic [31:0] stride;
        int          ack_delay;
        bit          gap;
        bit          restart;
        int          exp_reads;
        int          exp_win;
    } vec_t;
    vec_t vecs[6];

    // Responder knobs and monitor statistics
    int ack_delay = 0;
    bit gap_mode = 0;
    bit rsp_busy = 0;
    int cur_line = 0;
    int line_cnt[4] = '{0, 0, 0, 0};
    int rd_cnt = 0;
    int win_cnt = 0;
    int done_cnt = 0;

    // Read responder: acks after ack_delay cycles, then returns LW words.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (o_rd_req && !i_rst) begin
                logic [31:0] addr0;
                int w;
                bit tog;
                rsp_busy = 1;
                addr0 = o_rd_addr;
                for (int d = 0; d < ack_delay; d++) begin
                    @(posedge clk); #1;
                    chk("req_stable", {31'd0, o_rd_req, o_rd_addr}, {31'd0, 1'b1, addr0});
                end
                i_rd_ack = 1'b1;
                @(posedge clk); #1;
                i_rd_ack = 1'b0;
                w = 0;
                tog = 0;
                while (w < LW) begin
                    if (gap_mode && tog) begin
                        i_rd_data_valid = 1'b0;
                    end else begin
                        i_rd_data_valid = 1'b1;
                        i_rd_data = {$urandom, $urandom};
                        w++;
                    end
                    tog = !tog;
                    @(posedge clk); #1;
                end
                i_rd_data_valid = 1'b0;
                rsp_busy = 0;
            end
        end
    end

    // Downstream consumer: random output beats, including outside FILTER.
    initial begin
        forever begin
            @(posedge clk); #1;
            i_out_beat = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard pops on ack, strobe routing, filter window length, drain gap.
    initial begin
        logic [2:0] s;
        bit prev_filter;
        int win_beats;
        int gap;
        rd_exp_t e;
        prev_filter = 0;
        win_beats = 0;
        gap = -1;
        forever begin
            @(negedge clk);
            s = {o_line3_data_valid, o_line2_data_valid, o_line1_data_valid};
            if (s != 3'b000) begin
                if (cur_line == 0 || !i_rd_data_valid) begin
                    chk("strobe_unexpected", {61'd0, s}, 64'd0);
                end else begin
                    chk("strobe_route", {61'd0, s}, 64'(3'b001 << (cur_line - 1)));
                    chk("line_data", o_line_data, i_rd_data);
                    line_cnt[cur_line]++;
                end
            end
            if (o_rd_req && i_rd_ack) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_req", {32'd0, o_rd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_addr", {32'd0, o_rd_addr}, {32'd0, e.addr});
                    cur_line = e.line;
                    rd_cnt++;
                end
            end
            if (gap >= 0) begin
                if (o_rd_req || o_done) begin
                    chk("drain_gap", 64'(gap), 64'd2);
                    gap = -1;
                end else begin
                    gap++;
                end
            end
            if (o_filter && i_out_beat) win_beats++;
            if (prev_filter && !o_filter) begin
                chk("filter_beats", 64'(win_beats), 64'(LW));
                win_beats = 0;
                win_cnt++;
                gap = 1;
            end
            prev_filter = o_filter;
            if (o_done) done_cnt++;
            if (i_rst) begin
                cur_line = 0;
                rd_q.delete();
                win_beats = 0;
                gap = -1;
            end
        end
    end

    task automatic push_reads(input int n_rows, input logic [31:0] base, input logic [31:0] stride);
        rd_exp_t e;
        logic [31:0] idx;
        for (int r = 0; r < n_rows - 2; r++) begin
            for (int s = 1; s <= 3; s++) begin
                idx = 32'(r + s - 1);
                e.addr = base + idx * stride;
                e.line = s;
                rd_q.push_back(e);
            end
        end
    endtask

    task automatic start_job(input int n_rows, input logic [31:0] base, input logic [31:0] stride);
        @(posedge clk); #1;
        i_num_rows = 12'(n_rows);
        i_base_addr = base;
        i_stride = stride;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        // Scramble config after accept: the DUT must use its latched copy.
        i_base_addr = ~base;
        i_stride = stride + 32'h40;
        i_num_rows = 12'd9;
    endtask

    task automatic run_job(input int idx, input vec_t v);
        int rd0, win0, done0, l1, l2, l3, cyc;
        bit got;
        rd0 = rd_cnt; win0 = win_cnt; done0 = done_cnt;
        l1 = line_cnt[1]; l2 = line_cnt[2]; l3 = line_cnt[3];
        ack_delay = v.ack_delay;
        gap_mode = v.gap;
        push_reads(v.n_rows, v.base, v.stride);
        start_job(v.n_rows, v.base, v.stride);
        cyc = 0;
        got = 0;
        for (int k = 0; k < 20000 && !got; k++) begin
            @(negedge clk);
            if (o_busy) cyc++;
            if (o_done) got = 1;
            i_start = (v.restart && cyc == 50);
        end
        i_start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        if (v.n_rows < 3) chk("done_latency", 64'(cyc), 64'd1);
        repeat (5) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - done0), 64'd1);
        chk("read_count", 64'(rd_cnt - rd0), 64'(v.exp_reads));
        chk("line1_strobes", 64'(line_cnt[1] - l1), 64'(v.exp_win * LW));
        chk("line2_strobes", 64'(line_cnt[2] - l2), 64'(v.exp_win * LW));
        chk("line3_strobes", 64'(line_cnt[3] - l3), 64'(v.exp_win * LW));
        chk("filter_windows", 64'(win_cnt - win0), 64'(v.exp_win));
        chk("reads_left", 64'(rd_q.size()), 64'd0);
        chk("idle_busy", 64'(o_busy), 64'd0);
`ifdef SCHED_PERF_CNT_EN
        chk("job_cycles", {32'd0, o_job_cycles}, 64'(cyc));
`endif
        $display("job %0d rows=%0d base=0x%0h stride=0x%0h cycles=%0d reads=%0d",
                 idx, v.n_rows, v.base, v.stride, cyc, rd_cnt - rd0);
        rd_q.delete();
    endtask

    initial begin
        vecs[0] = '{3, 32'h1000, 32'h200, 0, 1'b0, 1'b0, 3, 1};
        vecs[1] = '{5, 32'h1000, 32'h200, 0, 1'b0, 1'b1, 9, 3};
        vecs[2] = '{3, 32'h1000, 32'h200, 10, 1'b1, 1'b0, 3, 1};
        vecs[3] = '{2, 32'h1000, 32'h200, 0, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{4, 32'hFFFF_FF00, 32'h100, 2, 1'b1, 1'b0, 6, 2};
        vecs[5] = '{0, 32'h2000, 32'h80, 0, 1'b0, 1'b0, 0, 0};

        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {57'd0, o_rd_req, o_filter, o_busy, o_done,
                              o_line1_data_valid, o_line2_data_valid, o_line3_data_valid}, 64'd0);
        chk("reset_addr", {32'd0, o_rd_addr}, 64'd0);
`ifdef SCHED_PERF_CNT_EN
        chk("reset_job_cycles", {32'd0, o_job_cycles}, 64'd0);
`endif

        for (int i = 0; i < 6; i++) run_job(i, vecs[i]);

        // Reset in FILL after 20 line-1 beats: job abandoned, no o_done.
        begin
            int done0, l0;
            bit hit;
            done0 = done_cnt;
            l0 = line_cnt[1];
            ack_delay = 0;
            gap_mode = 0;
            push_reads(3, 32'h1000, 32'h200);
            start_job(3, 32'h1000, 32'h200);
            hit = 0;
            for (int k = 0; k < 2000 && !hit; k++) begin
                @(negedge clk);
                if (line_cnt[1] - l0 >= 20) hit = 1;
            end
            chk("reached_20_beats", 64'(hit), 64'd1);
            @(posedge clk); #1;
            i_rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("midjob_reset_outputs", {57'd0, o_rd_req, o_filter, o_busy, o_done,
                                         o_line1_data_valid, o_line2_data_valid,
                                         o_line3_data_valid}, 64'd0);
            @(posedge clk); #1;
            i_rst = 1'b0;
            hit = 0;
            for (int k = 0; k < 500 && !hit; k++) begin
                @(negedge clk);
                if (!rsp_busy) hit = 1;
            end
            chk("responder_idle", 64'(hit), 64'd1);
            chk("no_done_after_reset", 64'(done_cnt - done0), 64'd0);
            chk("idle_after_reset", 64'(o_busy), 64'd0);
            $display("job reset-in-fill abandoned after %0d line1 beats", line_cnt[1] - l0);
        end

        run_job(6, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
